// File: rtl/boot_cmd_engine_if.sv
// Word-addressed memory port between the boot command engine and its memory.
// The engine drives the request side and the memory returns ack and read data.
interface boot_cmd_engine_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              MEM_REQ;
    logic              MEM_WE;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [31:0]       MEM_WDATA;
    logic              MEM_ACK;
    logic [31:0]       MEM_RDATA;

    modport master (
        output MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA,
        input  MEM_ACK, MEM_RDATA
    );

    modport slave (
        input  MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA,
        output MEM_ACK, MEM_RDATA
    );
endinterface

// File: rtl/boot_cmd_engine.sv
// Bootloader command engine: assembles six SPI bytes into CMD/FLAGS/DATA frames
// and executes them against a req/ack memory port, with readback and boot release.
module boot_cmd_engine #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned TIMEOUT  = 1023,
    parameter logic [31:0] BOOT_KEY = 32'hB007C0DE
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [7:0]          B0,
    input  logic [7:0]          B1,
    input  logic [7:0]          B2,
    input  logic [7:0]          B3,
    input  logic [7:0]          B4,
    input  logic [7:0]          B5,
    input  logic [5:0]          BSTROBE,
    output logic [31:0]         RDBK,
    output logic                BUSY,
    output logic                BOOT_GO,
    output logic [7:0]          ERRCNT,
    boot_cmd_engine_if.master   mem
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t            state_q, state_d;
    logic [2:0]        idx_q, idx_d;
    logic [7:0]        cmd_q, cmd_d;
    logic              auto_q, auto_d;
    logic [31:0]       data_q, data_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              inc_q, inc_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [31:0]       rdbk_q, rdbk_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              busy_q, busy_d;
    logic              boot_q, boot_d;
    logic [7:0]        errcnt_q, errcnt_d;
    logic              err;
    logic [5:0]        exp_strobe;
    logic [31:0]       ptr_ext;
    logic              unused_bits;

    assign ptr_ext     = 32'(ptr_q);
    assign exp_strobe  = 6'(1) << idx_q;
    assign unused_bits = ^{B1[7:1], ptr_ext[31:16]};

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cmd_d    = cmd_q;
        auto_d   = auto_q;
        data_d   = data_q;
        done_d   = 1'b0;
        ptr_d    = ptr_q;
        inc_d    = inc_q;
        cnt_d    = cnt_q;
        rdbk_d   = rdbk_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        busy_d   = busy_q;
        boot_d   = boot_q;
        errcnt_d = errcnt_q;
        err      = 1'b0;

        // Frame assembly; multi-bit strobes never match a single expected bit.
        if (BSTROBE == 6'b000001) begin
            cmd_d = B0;
            idx_d = 3'd1;
        end else if (BSTROBE != '0) begin
            if (idx_q != 3'd0 && BSTROBE == exp_strobe) begin
                idx_d = idx_q + 3'd1;
                case (idx_q)
                    3'd1:    auto_d = B1[0];
                    3'd2:    data_d[31:24] = B2;
                    3'd3:    data_d[23:16] = B3;
                    3'd4:    data_d[15:8]  = B4;
                    default: begin
                        data_d[7:0] = B5;
                        done_d      = 1'b1;
                        idx_d       = 3'd0;
                    end
                endcase
            end else begin
                idx_d = 3'd0;
                err   = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (done_q) begin
                    case (cmd_q)
                        8'h01: ptr_d = data_q[ADDR_W-1:0];
                        8'h02, 8'h03: begin
                            addr_d  = ptr_q;
                            we_d    = (cmd_q == 8'h02);
                            wdata_d = data_q;
                            inc_d   = auto_q;
                            req_d   = 1'b1;
                            busy_d  = 1'b1;
                            cnt_d   = '0;
                            state_d = REQ;
                        end
                        8'h04: begin
                            if (data_q == BOOT_KEY) boot_d = 1'b1;
                            else                    err    = 1'b1;
                        end
                        8'h05: rdbk_d = {boot_q, 7'b0, errcnt_q, ptr_ext[15:0]};
                        default: err = 1'b1;
                    endcase
                end
            end
            REQ, WAIT: begin
                if (done_q) err = 1'b1;
                if (mem.MEM_ACK) begin
                    if (!we_q) rdbk_d = mem.MEM_RDATA;
                    if (inc_q) ptr_d = ptr_q + 1'b1;
                    req_d   = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (cnt_q == 32'(TIMEOUT - 1)) begin
                    err     = 1'b1;
                    req_d   = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_q + 32'd1;
                    state_d = WAIT;
                end
            end
            default: state_d = IDLE;
        endcase

        // All error sources in a cycle collapse into one saturating increment.
        if (err && errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cmd_q    <= '0;
            auto_q   <= 1'b0;
            data_q   <= '0;
            done_q   <= 1'b0;
            ptr_q    <= '0;
            inc_q    <= 1'b0;
            cnt_q    <= '0;
            rdbk_q   <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            busy_q   <= 1'b0;
            boot_q   <= 1'b0;
            errcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cmd_q    <= cmd_d;
            auto_q   <= auto_d;
            data_q   <= data_d;
            done_q   <= done_d;
            ptr_q    <= ptr_d;
            inc_q    <= inc_d;
            cnt_q    <= cnt_d;
            rdbk_q   <= rdbk_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            busy_q   <= busy_d;
            boot_q   <= boot_d;
            errcnt_q <= errcnt_d;
        end
    end

    assign RDBK          = rdbk_q;
    assign BUSY          = busy_q;
    assign BOOT_GO       = boot_q;
    assign ERRCNT        = errcnt_q;
    assign mem.MEM_REQ   = req_q;
    assign mem.MEM_WE    = we_q;
    assign mem.MEM_ADDR  = addr_q;
    assign mem.MEM_WDATA = wdata_q;
endmodule

// File: tb/tb_boot_cmd_engine.sv
// Directed bench for boot_cmd_engine: frames driven on the falling edge,
// outputs sampled on the falling edge, memory acks driven by hand.
module tb_boot_cmd_engine;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [7:0]  B0 = '0, B1 = '0, B2 = '0, B3 = '0, B4 = '0, B5 = '0;
    logic [5:0]  BSTROBE = '0;
    logic [31:0] RDBK;
    logic        BUSY, BOOT_GO;
    logic [7:0]  ERRCNT;
    int          checks = 0;
    int          errors = 0;

    boot_cmd_engine_if #(.ADDR_W(16)) mif ();

    boot_cmd_engine #(.ADDR_W(16), .TIMEOUT(1023), .BOOT_KEY(32'hB007C0DE)) dut (
        .CLK(CLK), .RST(RST),
        .B0(B0), .B1(B1), .B2(B2), .B3(B3), .B4(B4), .B5(B5),
        .BSTROBE(BSTROBE), .RDBK(RDBK), .BUSY(BUSY), .BOOT_GO(BOOT_GO),
        .ERRCNT(ERRCNT), .mem(mif)
    );

    always #5 CLK = ~CLK;

    task automatic send_byte(input logic [5:0] mask, input logic [7:0] val);
        @(negedge CLK);
        BSTROBE = mask;
        B0 = val; B1 = val; B2 = val; B3 = val; B4 = val; B5 = val;
    endtask

    task automatic idle();
        @(negedge CLK);
        BSTROBE = '0;
    endtask

    // Returns in the middle of the dispatch cycle.
    task automatic send_frame(input logic [7:0] c, input logic [7:0] f, input logic [31:0] d);
        send_byte(6'b000001, c);
        send_byte(6'b000010, f);
        send_byte(6'b000100, d[31:24]);
        send_byte(6'b001000, d[23:16]);
        send_byte(6'b010000, d[15:8]);
        send_byte(6'b100000, d[7:0]);
        idle();
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic ack_now(input logic [31:0] rd);
        mif.MEM_ACK = 1'b1;
        mif.MEM_RDATA = rd;
        @(negedge CLK);
        mif.MEM_ACK = 1'b0;
    endtask

    task automatic test_reset();
        mif.MEM_ACK = 1'b0;
        mif.MEM_RDATA = '0;
        do_reset();
        checks++;
        if ({RDBK, mif.MEM_REQ, mif.MEM_WE, mif.MEM_ADDR, mif.MEM_WDATA, BUSY, BOOT_GO, ERRCNT} !== '0) begin
            errors++;
            $display("FAIL reset_outputs rdbk=%h req=%b we=%b addr=%h wdata=%h busy=%b go=%b err=%h expected all zero",
                     RDBK, mif.MEM_REQ, mif.MEM_WE, mif.MEM_ADDR, mif.MEM_WDATA, BUSY, BOOT_GO, ERRCNT);
        end
    endtask

    task automatic test_write_status();
        send_frame(8'h01, 8'h00, 32'h0000_0010);
        send_frame(8'h02, 8'h01, 32'hDEAD_BEEF);
        @(negedge CLK);
        checks++;
        if ({mif.MEM_REQ, mif.MEM_WE, BUSY, mif.MEM_ADDR, mif.MEM_WDATA} !== {3'b111, 16'h0010, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL write_req req=%b we=%b busy=%b addr=%h wdata=%h expected 1 1 1 0010 deadbeef",
                     mif.MEM_REQ, mif.MEM_WE, BUSY, mif.MEM_ADDR, mif.MEM_WDATA);
        end
        @(negedge CLK);
        checks++;
        if ({mif.MEM_REQ, mif.MEM_ADDR, mif.MEM_WDATA} !== {1'b1, 16'h0010, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL write_hold req=%b addr=%h wdata=%h expected 1 0010 deadbeef",
                     mif.MEM_REQ, mif.MEM_ADDR, mif.MEM_WDATA);
        end
        @(negedge CLK);
        ack_now(32'h0);
        checks++;
        if ({mif.MEM_REQ, BUSY} !== 2'b00) begin
            errors++;
            $display("FAIL write_done req=%b busy=%b expected 0 0", mif.MEM_REQ, BUSY);
        end
        send_frame(8'h05, 8'h00, 32'h0);
        @(negedge CLK);
        checks++;
        if (RDBK !== 32'h0000_0011) begin
            errors++;
            $display("FAIL status_autoinc rdbk=%h expected 00000011", RDBK);
        end
    endtask

    task automatic test_read();
        send_frame(8'h03, 8'h00, 32'h0);
        @(negedge CLK);
        checks++;
        if ({mif.MEM_REQ, mif.MEM_WE, mif.MEM_ADDR} !== {2'b10, 16'h0011}) begin
            errors++;
            $display("FAIL read_req req=%b we=%b addr=%h expected 1 0 0011", mif.MEM_REQ, mif.MEM_WE, mif.MEM_ADDR);
        end
        ack_now(32'h1234_5678);
        checks++;
        if ({RDBK, mif.MEM_REQ, BUSY} !== {32'h12345678, 2'b00}) begin
            errors++;
            $display("FAIL read_data rdbk=%h req=%b busy=%b expected 12345678 0 0", RDBK, mif.MEM_REQ, BUSY);
        end
        send_frame(8'h05, 8'h00, 32'h0);
        @(negedge CLK);
        checks++;
        if (RDBK !== 32'h0000_0011) begin
            errors++;
            $display("FAIL read_ptr_kept rdbk=%h expected 00000011", RDBK);
        end
    endtask

    task automatic test_boot();
        send_frame(8'h04, 8'h00, 32'hB007_C0DE);
        @(negedge CLK);
        checks++;
        if ({BOOT_GO, ERRCNT} !== {1'b1, 8'd0}) begin
            errors++;
            $display("FAIL boot_key go=%b err=%0d expected 1 0", BOOT_GO, ERRCNT);
        end
        send_frame(8'h7E, 8'h00, 32'h0);
        @(negedge CLK);
        checks++;
        if ({BOOT_GO, ERRCNT} !== {1'b1, 8'd1}) begin
            errors++;
            $display("FAIL boot_sticky_badcmd go=%b err=%0d expected 1 1", BOOT_GO, ERRCNT);
        end
    endtask

    task automatic test_reset_mid_wait();
        send_frame(8'h02, 8'h00, 32'hCAFE_F00D);
        @(negedge CLK);
        @(negedge CLK);
        checks++;
        if (mif.MEM_REQ !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_req req=%b expected 1", mif.MEM_REQ);
        end
        RST = 1'b1;
        #1;
        checks++;
        if ({RDBK, mif.MEM_REQ, mif.MEM_WE, mif.MEM_ADDR, mif.MEM_WDATA, BUSY, BOOT_GO, ERRCNT} !== '0) begin
            errors++;
            $display("FAIL rst_async rdbk=%h req=%b we=%b addr=%h wdata=%h busy=%b go=%b err=%h expected all zero",
                     RDBK, mif.MEM_REQ, mif.MEM_WE, mif.MEM_ADDR, mif.MEM_WDATA, BUSY, BOOT_GO, ERRCNT);
        end
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_boot_bad();
        send_frame(8'h04, 8'h00, 32'h0);
        @(negedge CLK);
        checks++;
        if ({BOOT_GO, ERRCNT} !== {1'b0, 8'd1}) begin
            errors++;
            $display("FAIL boot_badkey go=%b err=%0d expected 0 1", BOOT_GO, ERRCNT);
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        do_reset();
        send_frame(8'h02, 8'h01, 32'h5555_AAAA);
        for (int i = 0; i < 1100; i++) begin
            @(negedge CLK);
            if (mif.MEM_REQ) n++;
            else if (n > 0) break;
        end
        checks++;
        if (n != 1023) begin
            errors++;
            $display("FAIL timeout_len req_cycles=%0d expected 1023", n);
        end
        checks++;
        if ({ERRCNT, BUSY, mif.MEM_REQ} !== {8'd1, 2'b00}) begin
            errors++;
            $display("FAIL timeout_state err=%0d busy=%b req=%b expected 1 0 0", ERRCNT, BUSY, mif.MEM_REQ);
        end
        ack_now(32'hFFFF_FFFF);
        send_frame(8'h05, 8'h00, 32'h0);
        @(negedge CLK);
        checks++;
        if (RDBK !== 32'h0001_0000) begin
            errors++;
            $display("FAIL late_ack_ignored rdbk=%h expected 00010000", RDBK);
        end
    endtask

    task automatic test_strobe_order_busy();
        do_reset();
        send_frame(8'h01, 8'h00, 32'h0000_0042);
        send_byte(6'b000001, 8'h05);
        send_byte(6'b000010, 8'h00);
        send_frame(8'h05, 8'h00, 32'h0);
        @(negedge CLK);
        checks++;
        if ({ERRCNT, RDBK} !== {8'd0, 32'h0000_0042}) begin
            errors++;
            $display("FAIL partial_restart err=%0d rdbk=%h expected 0 00000042", ERRCNT, RDBK);
        end
        send_byte(6'b000001, 8'h05);
        send_byte(6'b000010, 8'h00);
        send_byte(6'b001000, 8'h00);
        idle();
        checks++;
        if (ERRCNT !== 8'd1) begin
            errors++;
            $display("FAIL out_of_order err=%0d expected 1", ERRCNT);
        end
        send_byte(6'b000001, 8'h05);
        send_byte(6'b000110, 8'h00);
        idle();
        checks++;
        if (ERRCNT !== 8'd2) begin
            errors++;
            $display("FAIL multi_bit_strobe err=%0d expected 2", ERRCNT);
        end
        send_frame(8'h02, 8'h00, 32'h0BAD_0BAD);
        send_frame(8'h05, 8'h00, 32'h0);
        @(negedge CLK);
        checks++;
        if ({ERRCNT, RDBK, mif.MEM_REQ, mif.MEM_ADDR} !== {8'd3, 32'h0000_0042, 1'b1, 16'h0042}) begin
            errors++;
            $display("FAIL busy_drop err=%0d rdbk=%h req=%b addr=%h expected 3 00000042 1 0042",
                     ERRCNT, RDBK, mif.MEM_REQ, mif.MEM_ADDR);
        end
        ack_now(32'h0);
    endtask

    task automatic test_wrap();
        send_frame(8'h01, 8'h00, 32'h0000_FFFF);
        send_frame(8'h02, 8'h01, 32'h1122_3344);
        @(negedge CLK);
        checks++;
        if ({mif.MEM_REQ, mif.MEM_ADDR, mif.MEM_WDATA} !== {1'b1, 16'hFFFF, 32'h11223344}) begin
            errors++;
            $display("FAIL wrap_req req=%b addr=%h wdata=%h expected 1 ffff 11223344",
                     mif.MEM_REQ, mif.MEM_ADDR, mif.MEM_WDATA);
        end
        ack_now(32'h0);
        send_frame(8'h05, 8'h00, 32'h0);
        @(negedge CLK);
        checks++;
        if (RDBK !== 32'h0003_0000) begin
            errors++;
            $display("FAIL wrap_ptr rdbk=%h expected 00030000", RDBK);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 10; i++) send_frame(8'hAA, 8'h00, 32'h0);
        @(negedge CLK);
        checks++;
        if (ERRCNT !== 8'd10) begin
            errors++;
            $display("FAIL errcnt_ten err=%0d expected 10", ERRCNT);
        end
        for (int i = 0; i < 290; i++) send_frame(8'hAA, 8'h00, 32'h0);
        @(negedge CLK);
        checks++;
        if (ERRCNT !== 8'd255) begin
            errors++;
            $display("FAIL errcnt_saturate err=%0d expected 255", ERRCNT);
        end
    endtask

    initial begin
        test_reset();
        test_write_status();
        test_read();
        test_boot();
        test_reset_mid_wait();
        test_boot_bad();
        test_timeout();
        test_strobe_order_busy();
        test_wrap();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/boot_cmd_engine.md
Name: boot_cmd_engine

Overview:
- Sits directly downstream of the SPI slave byte interface in the bootloader.
- Consumes the six received bytes and their one-hot strobes, and assembles them into a command frame: CMD, FLAGS, then DATA[31:0] big-endian.
- Executes each frame against a word-addressed memory port using a req/ack handshake.
- Supplies a 32-bit readback word to the slave for the next transaction, and raises BOOT_GO when a keyed boot command is received.

Parameters:
- ADDR_W, 16, memory word-address width (1..32).
- TIMEOUT, 1023, max CLK cycles to wait for MEM_ACK before abort (>=1).
- BOOT_KEY, 32'hB007C0DE, DATA value required by the BOOT command.

Ports:
- CLK  in  1  system clock; all logic on its rising edge.
- RST  in  1  asynchronous, active-high reset.
- B0..B5  in  8 each  received frame bytes 0..5 from the SPI slave; each byte is valid when its strobe bit is high.
- BSTROBE  in  6  one-hot byte strobe; bit n is a 1-cycle pulse meaning Bn was updated.
- RDBK  out  32  readback word for the slave; bytes 2..5 of the next frame shift out RDBK[31:24] first.
- MEM_REQ  out  1  memory request; held high until MEM_ACK.
- MEM_WE  out  1  1 = write, 0 = read; valid while MEM_REQ is high.
- MEM_ADDR  out  ADDR_W  word address.
- MEM_WDATA  out  32  write data.
- MEM_ACK  in  1  1-cycle completion pulse; for reads, MEM_RDATA is valid in the same cycle.
- MEM_RDATA  in  32  read data.
- BUSY  out  1  high while a frame is executing.
- BOOT_GO  out  1  sticky boot release.
- ERRCNT  out  8  saturating error counter.

Behaviour:
- Reset values: RDBK=0, MEM_REQ=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0, BUSY=0, BOOT_GO=0, ERRCNT=0; internal address pointer=0; state IDLE; byte-sequence index=0.

Frame assembly:
- BSTROBE[0] always restarts a frame: captures CMD=B0 and sets the index to 1.
- BSTROBE[n], n=1..5, is accepted only when index==n; it captures the byte and increments the index.
- An out-of-order strobe clears the index to 0, discards the frame and increments ERRCNT.
- A partial frame followed by a new BSTROBE[0] is discarded silently, with no error.
- Accepting BSTROBE[5] marks the frame complete. It is dispatched on the next cycle when the state is IDLE.
- If the state is not IDLE, the frame is dropped and ERRCNT increments.
- BSTROBE with more than one bit set: treated as out-of-order.

Commands (CMD byte; FLAGS[0] = auto-increment):
- 0x01 SETADDR: pointer <= DATA[ADDR_W-1:0]. Completes with no memory access; BUSY stays 0.
- 0x02 WRITE: memory write of DATA at the pointer.
- 0x03 READ: memory read at the pointer; RDBK <= MEM_RDATA on the MEM_ACK cycle.
- 0x04 BOOT: if DATA==BOOT_KEY, BOOT_GO <= 1; otherwise ERRCNT increments.
- 0x05 STATUS: RDBK <= {BOOT_GO, 7'b0, ERRCNT, zero-extended pointer[15:0]}.
- Any other CMD: ERRCNT increments and no other effect.

State machine IDLE -> REQ -> WAIT -> IDLE:
- IDLE: a complete WRITE/READ frame loads MEM_ADDR=pointer, MEM_WE and MEM_WDATA, sets MEM_REQ=1 and BUSY=1, and goes to REQ. The request is visible 1 cycle after the dispatch cycle.
- REQ/WAIT: MEM_REQ, MEM_WE, MEM_ADDR and MEM_WDATA are held stable. A cycle counter runs from 0.
- On MEM_ACK: MEM_REQ=0, BUSY=0, return to IDLE. If FLAGS[0]=1, pointer <= pointer+1, wrapping modulo 2^ADDR_W.
- MEM_ACK arriving in the first request cycle is legal.
- If the counter reaches TIMEOUT without an ack: drop MEM_REQ, increment ERRCNT, leave the pointer and RDBK unchanged, return to IDLE. A late MEM_ACK in IDLE is ignored.
- Frame assembly continues while BUSY; completion is handled by the drop rule above.

Other rules:
- ERRCNT saturates at 255.
- Simultaneous error events in one cycle increment ERRCNT by 1 only.
- RST mid-operation: MEM_REQ deasserts immediately (asynchronously) and all state returns to reset values, including BOOT_GO.

Test Plan:
- Frame 01,00,00,00,00,10 then 02,01,DE,AD,BE,EF -> MEM_REQ=1, WE=1, ADDR=0x0010, WDATA=DEADBEEF; ack on 3rd cycle -> REQ=0, BUSY=0; a following STATUS gives RDBK[15:0]=0x0011.
- READ frame 03,00,... with MEM_RDATA=12345678 and MEM_ACK in the first request cycle -> RDBK=0x12345678, pointer unchanged.
- BOOT with DATA=B007C0DE -> BOOT_GO=1 and stays 1; BOOT with DATA=00000000 on a fresh reset -> BOOT_GO=0, ERRCNT=1.
- WRITE with no MEM_ACK, TIMEOUT=1023 -> MEM_REQ drops after 1023 wait cycles, ERRCNT=1, BUSY=0; late ACK ignored.
- Strobe order 0,1,3 -> frame discarded, ERRCNT=1; second frame completed while BUSY -> dropped, ERRCNT=2. Pointer 0xFFFF with auto-increment write, ADDR_W=16 -> pointer=0x0000.
- RST asserted mid-WAIT -> MEM_REQ=0 within the same cycle, all outputs at reset values; 300 bad CMDs -> ERRCNT=255.
